id_ex_skid: RTL and testbench

Parametrised ID/EX pipeline stage register with a valid/ready handshake, a one-entry skid buffer, synchronous flush and a saturating stall counter. It sits between decode and execute and carries the ALU select, the two operands, the destination and the forwarding source fields. Invalid slots always present NOP/bubble values, so execute-stage forwarding never matches stale register addresses. Full throughput is one beat per cycle, with one cycle of latency.

---
 rtl/id_ex_skid_pkg.sv | 18 +
 rtl/pipe_skid_buf.sv | 78 +++++++
 rtl/id_ex_skid.sv | 118 +++++++++++
 tb/tb_id_ex_skid.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_skid_pkg.sv
// Shared constants and state encoding for the ID/EX stage register.
// NOP/bubble values are what execute sees whenever the stage holds no beat.
package id_ex_skid_pkg;

  localparam logic [7:0]  AluNop     = 8'h00;
  localparam logic [4:0]  NopRegAddr = 5'h00;
  localparam logic [31:0] Zero       = 32'h0000_0000;
  localparam logic        Enabled    = 1'b1;
  localparam logic        Disabled   = 1'b0;

  // Encoded as {main_v, skid_v} so the valid bits read straight off the state.
  typedef enum logic [1:0] {
    SkEmpty = 2'b00,
    SkOne   = 2'b10,
    SkTwo   = 2'b11
  } skid_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer with synchronous flush; 1-cycle latency.
// in_ready comes only from state registers, never combinationally from out_ready.
module pipe_skid_buf
  import id_ex_skid_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t  state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         accept;
  logic         retire;

  assign accept   = in_valid & in_ready & ~flush;
  assign retire   = out_valid & out_ready;
  assign out_data = main_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SkEmpty;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      main_q    <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      // Held payload is left in place; the bubble mux downstream hides it.
      state     <= SkEmpty;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        SkEmpty: begin
          if (accept) begin
            main_q    <= in_data;
            state     <= SkOne;
            out_valid <= 1'b1;
          end
        end
        SkOne: begin
          if (accept && !retire) begin
            skid_q   <= in_data;
            state    <= SkTwo;
            in_ready <= 1'b0;
          end else if (accept && retire) begin
            main_q <= in_data;
          end else if (retire) begin
            state     <= SkEmpty;
            out_valid <= 1'b0;
          end
        end
        SkTwo: begin
          if (retire) begin
            main_q   <= skid_q;
            state    <= SkOne;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= SkEmpty;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/id_ex_skid.sv
// ID/EX pipeline register with skid buffer, flush, x0 write masking and a stall counter.
// One cycle latency, one beat per cycle; in_ready drops only when the skid entry is occupied.
module id_ex_skid
  import id_ex_skid_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ALUSEL_W = 8,
  parameter int CNT_W    = 16,
  parameter int MASK_X0  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALUSEL_W-1:0] alusel,
  input  logic [DATA_W-1:0]   s1data,
  input  logic [DATA_W-1:0]   s2data,
  input  logic [ADDR_W-1:0]   rd,
  input  logic                regwe,
  input  logic [ADDR_W-1:0]   reg1addr,
  input  logic                reg1en,
  input  logic [ADDR_W-1:0]   reg2addr,
  input  logic                reg2en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALUSEL_W-1:0] alusel_o,
  output logic [DATA_W-1:0]   s1data_o,
  output logic [DATA_W-1:0]   s2data_o,
  output logic [ADDR_W-1:0]   rd_o,
  output logic                regwe_o,
  output logic [ADDR_W-1:0]   reg1addr_o,
  output logic                reg1en_o,
  output logic [ADDR_W-1:0]   reg2addr_o,
  output logic                reg2en_o,
  output logic [CNT_W-1:0]    stall_cnt
);

  typedef struct packed {
    logic [ALUSEL_W-1:0] alusel;
    logic [DATA_W-1:0]   s1data;
    logic [DATA_W-1:0]   s2data;
    logic [ADDR_W-1:0]   rd;
    logic                regwe;
    logic [ADDR_W-1:0]   reg1addr;
    logic                reg1en;
    logic [ADDR_W-1:0]   reg2addr;
    logic                reg2en;
  } payload_t;

  localparam int              W      = ALUSEL_W + 2 * DATA_W + 3 * ADDR_W + 3;
  localparam logic [CNT_W-1:0] CntMax = '1;

  payload_t in_pl;
  payload_t out_pl;
  logic     rd_is_x0;

  assign rd_is_x0 = (MASK_X0 != 0) && (rd == '0);

  always_comb begin
    in_pl          = '0;
    in_pl.alusel   = alusel;
    in_pl.s1data   = s1data;
    in_pl.s2data   = s2data;
    in_pl.rd       = rd;
    in_pl.regwe    = regwe & ~rd_is_x0;
    in_pl.reg1addr = reg1addr;
    in_pl.reg1en   = reg1en;
    in_pl.reg2addr = reg2addr;
    in_pl.reg2en   = reg2en;
  end

  pipe_skid_buf #(.W(W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl)
  );

  // An empty slot must look like a NOP so execute-stage forwarding never matches.
  always_comb begin
    alusel_o   = ALUSEL_W'(AluNop);
    s1data_o   = DATA_W'(Zero);
    s2data_o   = DATA_W'(Zero);
    rd_o       = ADDR_W'(NopRegAddr);
    regwe_o    = Disabled;
    reg1addr_o = ADDR_W'(NopRegAddr);
    reg1en_o   = Disabled;
    reg2addr_o = ADDR_W'(NopRegAddr);
    reg2en_o   = Disabled;
    if (out_valid) begin
      alusel_o   = out_pl.alusel;
      s1data_o   = out_pl.s1data;
      s2data_o   = out_pl.s2data;
      rd_o       = out_pl.rd;
      regwe_o    = out_pl.regwe;
      reg1addr_o = out_pl.reg1addr;
      reg1en_o   = out_pl.reg1en;
      reg2addr_o = out_pl.reg2addr;
      reg2en_o   = out_pl.reg2en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CntMax)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_skid.sv
// Bench for id_ex_skid: queue-based reference model compared every cycle, plus directed literal checks.
module tb_id_ex_skid;
  import id_ex_skid_pkg::*;

  typedef struct packed {
    logic [7:0]  alusel;
    logic [31:0] s1data;
    logic [31:0] s2data;
    logic [4:0]  rd;
    logic        regwe;
    logic [4:0]  reg1addr;
    logic        reg1en;
    logic [4:0]  reg2addr;
    logic        reg2en;
  } pl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  pl_t  cur = '0;

  logic        in_ready, out_valid;
  logic [7:0]  alusel_o;
  logic [31:0] s1data_o, s2data_o;
  logic [4:0]  rd_o, reg1addr_o, reg2addr_o;
  logic        regwe_o, reg1en_o, reg2en_o;
  logic [15:0] stall_cnt;

  logic        b_in_ready, b_out_valid;
  logic [7:0]  b_alusel_o;
  logic [31:0] b_s1data_o, b_s2data_o;
  logic [4:0]  b_rd_o, b_reg1addr_o, b_reg2addr_o;
  logic        b_regwe_o, b_reg1en_o, b_reg2en_o;
  logic [1:0]  b_stall_cnt;

  int checks = 0;
  int failures = 0;

  pl_t mq[$];
  int  m_cnt = 0;
  int  m_cnt2 = 0;
  bit  started = 0;

  always #5 clk = ~clk;

  id_ex_skid dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alusel(cur.alusel), .s1data(cur.s1data), .s2data(cur.s2data), .rd(cur.rd),
    .regwe(cur.regwe), .reg1addr(cur.reg1addr), .reg1en(cur.reg1en),
    .reg2addr(cur.reg2addr), .reg2en(cur.reg2en),
    .out_valid(out_valid), .out_ready(out_ready),
    .alusel_o(alusel_o), .s1data_o(s1data_o), .s2data_o(s2data_o), .rd_o(rd_o),
    .regwe_o(regwe_o), .reg1addr_o(reg1addr_o), .reg1en_o(reg1en_o),
    .reg2addr_o(reg2addr_o), .reg2en_o(reg2en_o), .stall_cnt(stall_cnt)
  );

  id_ex_skid #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .alusel(cur.alusel), .s1data(cur.s1data), .s2data(cur.s2data), .rd(cur.rd),
    .regwe(cur.regwe), .reg1addr(cur.reg1addr), .reg1en(cur.reg1en),
    .reg2addr(cur.reg2addr), .reg2en(cur.reg2en),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .alusel_o(b_alusel_o), .s1data_o(b_s1data_o), .s2data_o(b_s2data_o), .rd_o(b_rd_o),
    .regwe_o(b_regwe_o), .reg1addr_o(b_reg1addr_o), .reg1en_o(b_reg1en_o),
    .reg2addr_o(b_reg2addr_o), .reg2en_o(b_reg2en_o), .stall_cnt(b_stall_cnt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of at most two beats, front is what execute sees.
  always @(posedge clk) begin
    pl_t p;
    bit  stalled, retire, accept;
    if (rst) begin
      mq.delete();
      m_cnt  = 0;
      m_cnt2 = 0;
    end else begin
      stalled = (mq.size() > 0) && !out_ready;
      retire  = (mq.size() > 0) && out_ready;
      accept  = in_valid && (mq.size() < 2) && !flush;
      if (stalled) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (flush) begin
        mq.delete();
      end else begin
        if (retire) void'(mq.pop_front());
        if (accept) begin
          p = cur;
          if (p.rd == 5'd0) p.regwe = 1'b0;
          mq.push_back(p);
        end
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    pl_t exp_pl, act_pl, act2_pl;
    if (started) begin
      exp_pl = '0;
      exp_pl.alusel   = AluNop;
      exp_pl.s1data   = Zero;
      exp_pl.s2data   = Zero;
      exp_pl.rd       = NopRegAddr;
      exp_pl.reg1addr = NopRegAddr;
      exp_pl.reg2addr = NopRegAddr;
      if (mq.size() > 0) exp_pl = mq[0];
      act_pl  = {alusel_o, s1data_o, s2data_o, rd_o, regwe_o, reg1addr_o, reg1en_o, reg2addr_o, reg2en_o};
      act2_pl = {b_alusel_o, b_s1data_o, b_s2data_o, b_rd_o, b_regwe_o, b_reg1addr_o, b_reg1en_o,
                 b_reg2addr_o, b_reg2en_o};
      chk("out_valid", out_valid, mq.size() > 0);
      chk("in_ready", in_ready, mq.size() < 2);
      chk("payload", act_pl, exp_pl);
      chk("stall_cnt", stall_cnt, m_cnt);
      chk("stall_cnt_w2", b_stall_cnt, m_cnt2);
      chk("payload_w2", act2_pl, exp_pl);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] s1, input logic [4:0] rdv, input logic we);
    cur = '0;
    cur.alusel   = 8'h21;
    cur.s1data   = s1;
    cur.s2data   = ~s1;
    cur.rd       = rdv;
    cur.regwe    = we;
    cur.reg1addr = 5'd3;
    cur.reg1en   = 1'b1;
    in_valid     = 1'b1;
  endtask

  initial begin
    // Reset with a beat offered; it must not be captured.
    offer(32'hdead, 5'd9, 1'b1);
    cyc(); cyc();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    chk("rst_alusel", alusel_o, 8'h00);
    cyc();
    chk("rst_no_capture", out_valid, 1'b0);

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      offer(i, 5'd4, 1'b1);
      cyc();
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_data", s1data_o, i);
      chk("stream_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    cyc();
    chk("stream_drain", out_valid, 1'b0);
    chk("stream_cnt", stall_cnt, 16'd0);

    // Stall with a second beat landing in skid.
    offer(32'd101, 5'd4, 1'b1);
    cyc();
    out_ready = 1'b0;
    offer(32'd102, 5'd4, 1'b1);
    cyc();
    in_valid = 1'b0;
    chk("stall_in_ready", in_ready, 1'b0);
    chk("stall_head", s1data_o, 32'd101);
    cyc(); cyc();
    chk("stall_cnt3", stall_cnt, 16'd3);
    out_ready = 1'b1;
    cyc();
    chk("unstall_data", s1data_o, 32'd102);
    chk("unstall_ready", in_ready, 1'b1);
    cyc();
    chk("unstall_empty", out_valid, 1'b0);
    chk("unstall_cnt", stall_cnt, 16'd3);

    // Flush while two beats are held and a third is offered.
    offer(32'd201, 5'd6, 1'b1);
    cyc();
    out_ready = 1'b0;
    offer(32'd202, 5'd6, 1'b1);
    cyc();
    flush = 1'b1;
    offer(32'd203, 5'd7, 1'b1);
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    chk("flush_rd", rd_o, 5'd0);
    chk("flush_reg1en", reg1en_o, 1'b0);
    chk("flush_alusel", alusel_o, 8'h00);
    cyc();
    chk("flush_no_leak", out_valid, 1'b0);

    // x0 write masking.
    offer(32'd300, 5'd0, 1'b1);
    cyc();
    chk("mask_x0_regwe", regwe_o, 1'b0);
    offer(32'd301, 5'd5, 1'b1);
    cyc();
    chk("mask_x5_regwe", regwe_o, 1'b1);
    chk("mask_x5_rd", rd_o, 5'd5);
    in_valid = 1'b0;
    cyc();

    // Narrow counter saturation.
    rst = 1'b1; cyc(); rst = 1'b0;
    offer(32'd400, 5'd2, 1'b1);
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk("sat_cnt2", b_stall_cnt, (k < 3) ? k : 3);
    end

    // Reset while full, with a beat offered and execute ready.
    out_ready = 1'b1;
    cyc();
    offer(32'd500, 5'd2, 1'b1);
    cyc();
    out_ready = 1'b0;
    offer(32'd501, 5'd2, 1'b1);
    cyc();
    rst = 1'b1; out_ready = 1'b1;
    offer(32'd999, 5'd2, 1'b1);
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst2_valid", out_valid, 1'b0);
    chk("rst2_ready", in_ready, 1'b1);
    chk("rst2_cnt", stall_cnt, 16'd0);
    chk("rst2_s1data", s1data_o, 32'd0);
    cyc();
    chk("rst2_no_capture", out_valid, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cur.alusel   = 8'($urandom);
      cur.s1data   = $urandom;
      cur.s2data   = $urandom;
      cur.rd       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      cur.regwe    = 1'($urandom);
      cur.reg1addr = 5'($urandom);
      cur.reg1en   = 1'($urandom);
      cur.reg2addr = 5'($urandom);
      cur.reg2en   = 1'($urandom);
      in_valid     = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 2) != 0);
      flush        = ($urandom_range(0, 31) == 0);
      rst          = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    cyc();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
